// File: rtl/regfile_readback_pkg.sv
// ---------------------------------------------------------------------------
// regfile_readback_pkg
// Constants shared by the register file, the decode stage and the writeback
// stage.
//   RF_WIDTH  - data width of each architectural register
//   RF_DEPTH  - number of architectural registers (equals 2**RF_ADDR_W)
//   RF_ADDR_W - width of every register address
//   ZERO_REG  - index of the hardwired-zero register
// ---------------------------------------------------------------------------
package regfile_readback_pkg;

    localparam int RF_WIDTH  = 32;
    localparam int RF_DEPTH  = 32;
    localparam int RF_ADDR_W = 5;
    localparam int ZERO_REG  = 0;

endpackage : regfile_readback_pkg

// File: rtl/en_reg.sv
// ---------------------------------------------------------------------------
// en_reg
// Enabled storage register with synchronous active-high clear.
//   clk - clock, rising edge
//   clr - synchronous clear, wins over en
//   en  - load enable
//   d   - data in
//   q   - registered data out
// ---------------------------------------------------------------------------
module en_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            q_reg <= '0;
        end else if (en) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule : en_reg

// File: rtl/regfile_read_port.sv
// ---------------------------------------------------------------------------
// regfile_read_port
// Combinational next-value logic for one read port. Selects the addressed
// register from the flattened storage bus, substitutes the write data when the
// same register is being written this cycle, and forces register 0 to read 0.
//   raddr      - read address
//   storage    - flattened storage bus, register i at [i*WIDTH +: WIDTH]
//   we         - write enable of the write port
//   waddr      - write address
//   wdata      - write data
//   rdata_next - value to be captured by the port's output register
// ---------------------------------------------------------------------------
module regfile_read_port
    import regfile_readback_pkg::*;
#(
    parameter int WIDTH  = RF_WIDTH,
    parameter int DEPTH  = RF_DEPTH,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic [ADDR_W-1:0]      raddr,
    input  logic [DEPTH*WIDTH-1:0] storage,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata_next
);

    // Unpacked view of the storage bus so the mux is a plain array index.
    logic [WIDTH-1:0] regs [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_view
            assign regs[gi] = storage[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_comb begin
        rdata_next = regs[raddr];
        // Zero check comes first: a write aimed at register 0 must never
        // leak through the bypass, so the bypass below can skip its own
        // waddr != 0 test.
        if (raddr == ADDR_W'(ZERO_REG)) begin
            rdata_next = '0;
        end else if (we && (waddr == raddr)) begin
            rdata_next = wdata;
        end
    end

endmodule : regfile_read_port

// File: rtl/regfile_readback.sv
// ---------------------------------------------------------------------------
// regfile_readback
// Two-read, one-write register file with registered read ports, write-to-read
// bypass and a hardwired-zero register 0.
//   clk     - clock, all state updates on rising edge
//   clr     - synchronous active-high reset; clears storage and read outputs,
//             and drops any write in the same cycle
//   we      - write enable
//   waddr   - write address
//   wdata   - write data
//   raddr_a - read address, port A
//   raddr_b - read address, port B
//   rdata_a - registered read data, port A (1-cycle latency)
//   rdata_b - registered read data, port B (1-cycle latency)
// ---------------------------------------------------------------------------
module regfile_readback
    import regfile_readback_pkg::*;
#(
    parameter int WIDTH  = RF_WIDTH,
    parameter int DEPTH  = RF_DEPTH,
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_a,
    output logic [WIDTH-1:0]  rdata_b
);

    logic [DEPTH*WIDTH-1:0] storage_bus;
    logic [DEPTH-1:0]       wen;
    logic [WIDTH-1:0]       rdata_a_next;
    logic [WIDTH-1:0]       rdata_b_next;
    logic [WIDTH-1:0]       rdata_a_reg;
    logic [WIDTH-1:0]       rdata_b_reg;

    // One-hot write decode and storage. Slot 0 has no storage at all; its
    // slice of the bus is tied to zero.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (gi == ZERO_REG) begin : g_zero
                assign wen[gi] = 1'b0;
                assign storage_bus[gi*WIDTH +: WIDTH] = '0;
            end else begin : g_store
                assign wen[gi] = we && (waddr == ADDR_W'(gi));
                en_reg #(
                    .WIDTH (WIDTH)
                ) u_reg (
                    .clk (clk),
                    .clr (clr),
                    .en  (wen[gi]),
                    .d   (wdata),
                    .q   (storage_bus[gi*WIDTH +: WIDTH])
                );
            end
        end
    endgenerate

    regfile_read_port #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_port_a (
        .raddr      (raddr_a),
        .storage    (storage_bus),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .rdata_next (rdata_a_next)
    );

    regfile_read_port #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_port_b (
        .raddr      (raddr_b),
        .storage    (storage_bus),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .rdata_next (rdata_b_next)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            rdata_a_reg <= '0;
            rdata_b_reg <= '0;
        end else begin
            rdata_a_reg <= rdata_a_next;
            rdata_b_reg <= rdata_b_next;
        end
    end

    assign rdata_a = rdata_a_reg;
    assign rdata_b = rdata_b_reg;

endmodule : regfile_readback

// File: tb/tb_regfile_readback.sv
// ---------------------------------------------------------------------------
// tb_regfile_readback
// Directed self-checking bench for regfile_readback. Inputs change 1 time
// unit after a rising edge; outputs are checked at the same point, i.e. they
// show what the previous edge captured.
// ---------------------------------------------------------------------------
module tb_regfile_readback;

    logic        clk;
    logic        clr;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr_a;
    logic [4:0]  raddr_b;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;

    int checks = 0;
    int errors = 0;

    regfile_readback dut (
        .clk     (clk),
        .clr     (clr),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        raddr_a = 5'd5; raddr_b = 5'd5;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (rdata_a !== 32'h0 || rdata_b !== 32'h0) begin
                errors++;
                $display("FAIL reset_out cyc %0d: a=%h b=%h want 00000000", c, rdata_a, rdata_b);
            end else begin
                $display("reset cyc %0d: a=%h b=%h", c, rdata_a, rdata_b);
            end
        end
        clr = 1'b0; we = 1'b0; waddr = 5'd0; wdata = 32'h0;
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i);
            raddr_b = 5'(i);
            tick();
            checks++;
            if (rdata_a !== 32'h0 || rdata_b !== 32'h0) begin
                errors++;
                $display("FAIL reset_read r%0d: a=%h b=%h want 00000000", i, rdata_a, rdata_b);
            end else begin
                $display("reset read r%0d: a=%h b=%h", i, rdata_a, rdata_b);
            end
        end
    endtask

    task automatic test_basic();
        we = 1'b1; waddr = 5'd7; wdata = 32'h12345678;
        raddr_a = 5'd1; raddr_b = 5'd2;
        tick();
        we = 1'b0;
        raddr_a = 5'd7; raddr_b = 5'd7;
        tick();
        checks++;
        if (rdata_a !== 32'h12345678 || rdata_b !== 32'h12345678) begin
            errors++;
            $display("FAIL basic_r7: a=%h b=%h want 12345678", rdata_a, rdata_b);
        end else begin
            $display("basic read r7: a=%h b=%h", rdata_a, rdata_b);
        end
    endtask

    task automatic test_zero();
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        raddr_a = 5'd7; raddr_b = 5'd7;
        tick();
        we = 1'b0;
        raddr_a = 5'd0; raddr_b = 5'd0;
        tick();
        checks++;
        if (rdata_a !== 32'h0 || rdata_b !== 32'h0) begin
            errors++;
            $display("FAIL zero_after_write: a=%h b=%h want 00000000", rdata_a, rdata_b);
        end else begin
            $display("zero read after write: a=%h b=%h", rdata_a, rdata_b);
        end
        we = 1'b1; waddr = 5'd0; wdata = 32'hAAAA5555;
        raddr_a = 5'd0; raddr_b = 5'd7;
        tick();
        we = 1'b0;
        checks++;
        if (rdata_a !== 32'h0 || rdata_b !== 32'h12345678) begin
            errors++;
            $display("FAIL zero_same_cycle: a=%h want 00000000 b=%h want 12345678", rdata_a, rdata_b);
        end else begin
            $display("zero same-cycle: a=%h b=%h", rdata_a, rdata_b);
        end
    endtask

    task automatic test_bypass();
        we = 1'b1; waddr = 5'd9; wdata = 32'h11111111;
        tick();
        waddr = 5'd3; wdata = 32'h33333333;
        tick();
        waddr = 5'd9; wdata = 32'h22222222;
        raddr_a = 5'd9; raddr_b = 5'd3;
        tick();
        we = 1'b0;
        checks++;
        if (rdata_a !== 32'h22222222 || rdata_b !== 32'h33333333) begin
            errors++;
            $display("FAIL bypass_a: a=%h want 22222222 b=%h want 33333333", rdata_a, rdata_b);
        end else begin
            $display("bypass port A: a=%h b=%h", rdata_a, rdata_b);
        end
        raddr_a = 5'd9; raddr_b = 5'd9;
        tick();
        checks++;
        if (rdata_a !== 32'h22222222 || rdata_b !== 32'h22222222) begin
            errors++;
            $display("FAIL bypass_stored: a=%h b=%h want 22222222", rdata_a, rdata_b);
        end else begin
            $display("bypass stored r9: a=%h b=%h", rdata_a, rdata_b);
        end
        // Both ports bypassing the same write.
        we = 1'b1; waddr = 5'd3; wdata = 32'h3C3C3C3C;
        raddr_a = 5'd3; raddr_b = 5'd3;
        tick();
        we = 1'b0;
        checks++;
        if (rdata_a !== 32'h3C3C3C3C || rdata_b !== 32'h3C3C3C3C) begin
            errors++;
            $display("FAIL bypass_both: a=%h b=%h want 3c3c3c3c", rdata_a, rdata_b);
        end else begin
            $display("bypass both ports: a=%h b=%h", rdata_a, rdata_b);
        end
    endtask

    task automatic test_sweep();
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [31:0] prev_a;
        logic [31:0] prev_b;
        we = 1'b1;
        raddr_a = 5'd0; raddr_b = 5'd0;
        for (int i = 1; i < 32; i++) begin
            waddr = 5'(i);
            wdata = 32'hA0000000 | 32'(i);
            tick();
        end
        we = 1'b0;
        tick();
        prev_a = 32'h0;
        prev_b = 32'h0;
        for (int i = 0; i < 32; i++) begin
            raddr_a = 5'(i);
            raddr_b = 5'(31 - i);
            exp_a = (i == 0) ? 32'h0 : (32'hA0000000 | 32'(i));
            exp_b = (i == 31) ? 32'h0 : (32'hA0000000 | 32'(31 - i));
            #2;
            // New addresses must not reach the outputs before the edge.
            checks++;
            if (rdata_a !== prev_a || rdata_b !== prev_b) begin
                errors++;
                $display("FAIL sweep_hold step %0d: a=%h want %h b=%h want %h", i, rdata_a, prev_a, rdata_b, prev_b);
            end
            tick();
            checks++;
            if (rdata_a !== exp_a || rdata_b !== exp_b) begin
                errors++;
                $display("FAIL sweep_read a=r%0d b=r%0d: a=%h want %h b=%h want %h", i, 31 - i, rdata_a, exp_a, rdata_b, exp_b);
            end else begin
                $display("sweep a=r%0d b=r%0d: a=%h b=%h", i, 31 - i, rdata_a, rdata_b);
            end
            prev_a = exp_a;
            prev_b = exp_b;
        end
    endtask

    task automatic test_reset_mid();
        clr = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'h44;
        raddr_a = 5'd4; raddr_b = 5'd31;
        tick();
        clr = 1'b0; we = 1'b0;
        checks++;
        if (rdata_a !== 32'h0 || rdata_b !== 32'h0) begin
            errors++;
            $display("FAIL midreset_out: a=%h b=%h want 00000000", rdata_a, rdata_b);
        end else begin
            $display("mid reset out: a=%h b=%h", rdata_a, rdata_b);
        end
        tick();
        checks++;
        if (rdata_a !== 32'h0 || rdata_b !== 32'h0) begin
            errors++;
            $display("FAIL midreset_r4_r31: a=%h b=%h want 00000000", rdata_a, rdata_b);
        end else begin
            $display("mid reset r4/r31: a=%h b=%h", rdata_a, rdata_b);
        end
        we = 1'b1; waddr = 5'd4; wdata = 32'h55;
        raddr_a = 5'd1; raddr_b = 5'd9;
        tick();
        we = 1'b0;
        checks++;
        if (rdata_a !== 32'h0 || rdata_b !== 32'h0) begin
            errors++;
            $display("FAIL midreset_cleared: a=%h b=%h want 00000000", rdata_a, rdata_b);
        end else begin
            $display("mid reset r1/r9: a=%h b=%h", rdata_a, rdata_b);
        end
        raddr_a = 5'd4; raddr_b = 5'd4;
        tick();
        checks++;
        if (rdata_a !== 32'h55 || rdata_b !== 32'h55) begin
            errors++;
            $display("FAIL midreset_rewrite: a=%h b=%h want 00000055", rdata_a, rdata_b);
        end else begin
            $display("mid reset rewrite r4: a=%h b=%h", rdata_a, rdata_b);
        end
    endtask

    initial begin
        clr = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        raddr_a = '0; raddr_b = '0;
        test_reset();
        test_basic();
        test_zero();
        test_bypass();
        test_sweep();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_regfile_readback
